bsr_stack_ctrl: RTL

- Controller and arbiter for the bidirectional serial shift register (DEPTH-bit bit-stack: push shifts `in` into the top, pop shifts toward the top).
- Accepts word-level push/pop requests from two clients, A and B, with round-robin arbitration.
- Serializes each push word into the stack one bit per cycle. Deserializes pop words from the stack top.
- Tracks occupancy, rejects overflow and underflow requests, and drives the shift register's enb/dir/in/rstn pins.

---
 rtl/bsr_stack_pkg.sv | 20 ++
 rtl/bsr_rr_arb2.sv | 31 +++
 rtl/bsr_stack_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/bsr_stack_pkg.sv
// Shared types and constants for the bit-stack controller.
// No logic, no latency; naming only.
package bsr_stack_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic OP_PUSH = 1'b1;
    localparam logic OP_POP  = 1'b0;
    localparam logic ID_A    = 1'b0;
    localparam logic ID_B    = ~ID_A;

    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/bsr_rr_arb2.sv
// Two-requester round-robin arbiter; combinational grant, last winner registered on i_advance.
// No backpressure: a grant is offered every cycle any request is high.
module bsr_rr_arb2
    import bsr_stack_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_advance,
    output logic [1:0] o_gnt
);

    logic r_last;

    always_comb begin
        o_gnt = i_req;
        if (i_req == 2'b11) begin
            o_gnt = (r_last == ID_B) ? 2'b01 : 2'b10;
        end
    end

    // Resetting to B hands the first contested grant to A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= ID_B;
        end else if (i_advance && (|o_gnt)) begin
            r_last <= o_gnt[1];
        end
    end

endmodule

// File: rtl/bsr_stack_ctrl.sv
// Word push/pop controller for a serial bit-stack; rsp_valid WORD_W+1 cycles after gnt (1 if rejected).
// Requests wait in IDLE until granted; BSR_STACK_CTRL_STATS_EN adds saturating ovf/unf counters.
module bsr_stack_ctrl
    import bsr_stack_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int WORD_W = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       a_req,
    input  logic                       a_op,
    input  logic [WORD_W-1:0]          a_wdata,
    output logic                       a_gnt,
    input  logic                       b_req,
    input  logic                       b_op,
    input  logic [WORD_W-1:0]          b_wdata,
    output logic                       b_gnt,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic                       rsp_err,
    output logic [WORD_W-1:0]          rsp_rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
`ifdef BSR_STACK_CTRL_STATS_EN
    output logic [7:0]                 ovf_cnt,
    output logic [7:0]                 unf_cnt,
`endif
    output logic                       sr_enb,
    output logic                       sr_dir,
    output logic                       sr_in,
    input  logic                       sr_top,
    output logic                       sr_rstn
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int IDX_W = idx_width(WORD_W);

    state_t              r_state, w_state_nxt;
    logic [CNT_W-1:0]    r_count;
    logic [IDX_W-1:0]    r_idx;
    logic                r_id, r_op, r_err;
    logic [WORD_W-1:0]   r_wdata;
    logic                r_a_gnt, r_b_gnt;
    logic                r_rsp_valid, r_rsp_id, r_rsp_err;
    logic [WORD_W-1:0]   r_rsp_rdata;
    logic                r_sr_enb, r_sr_dir, r_sr_in, r_sr_rstn;

    logic [1:0]          w_gnt;
    logic                w_grant, w_gnt_id, w_gnt_op, w_fit;
    logic [WORD_W-1:0]   w_gnt_wdata, w_rdata_shift;
    logic                w_sr_enb_nxt, w_sr_dir_nxt, w_sr_in_nxt, w_rsp_valid_nxt;

    bsr_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     ({b_req, a_req}),
        .i_advance (w_grant),
        .o_gnt     (w_gnt)
    );

    always_comb begin
        w_grant     = (r_state == IDLE) && (|w_gnt);
        w_gnt_id    = w_gnt[1] ? ID_B : ID_A;
        w_gnt_op    = w_gnt[1] ? b_op : a_op;
        w_gnt_wdata = w_gnt[1] ? b_wdata : a_wdata;
        if (w_gnt_op == OP_PUSH) begin
            w_fit = (int'(r_count) + WORD_W) <= DEPTH;
        end else begin
            w_fit = int'(r_count) >= WORD_W;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Pin drives lag the state by one cycle, so the last SHIFT bit lands on the RESP edge.
    always_comb begin
        w_state_nxt     = r_state;
        w_sr_enb_nxt    = 1'b0;
        w_sr_dir_nxt    = 1'b0;
        w_sr_in_nxt     = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_grant) begin
                    w_state_nxt = w_fit ? SHIFT : RESP;
                end
            end
            SHIFT: begin
                w_sr_enb_nxt = 1'b1;
                w_sr_dir_nxt = r_op;
                w_sr_in_nxt  = (r_op == OP_PUSH) ? r_wdata[r_idx] : 1'b0;
                if (r_idx == IDX_W'(WORD_W-1)) begin
                    w_state_nxt = RESP;
                end
            end
            RESP: begin
                w_rsp_valid_nxt = 1'b1;
                w_state_nxt     = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    generate
        if (WORD_W > 1) begin : g_shift_multi
            assign w_rdata_shift = {r_rsp_rdata[WORD_W-2:0], sr_top};
        end else begin : g_shift_single
            assign w_rdata_shift = sr_top;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count     <= '0;
            r_idx       <= '0;
            r_id        <= 1'b0;
            r_op        <= 1'b0;
            r_err       <= 1'b0;
            r_wdata     <= '0;
            r_a_gnt     <= 1'b0;
            r_b_gnt     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
            r_sr_enb    <= 1'b0;
            r_sr_dir    <= 1'b0;
            r_sr_in     <= 1'b0;
            r_sr_rstn   <= 1'b0;
        end else begin
            r_sr_rstn   <= 1'b1;
            r_a_gnt     <= w_grant && (w_gnt_id == ID_A);
            r_b_gnt     <= w_grant && (w_gnt_id == ID_B);
            r_sr_enb    <= w_sr_enb_nxt;
            r_sr_dir    <= w_sr_dir_nxt;
            r_sr_in     <= w_sr_in_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_rsp_id    <= w_rsp_valid_nxt && r_id;
            r_rsp_err   <= w_rsp_valid_nxt && r_err;

            if (w_grant) begin
                r_id    <= w_gnt_id;
                r_op    <= w_gnt_op;
                r_wdata <= w_gnt_wdata;
                r_err   <= ~w_fit;
                r_idx   <= '0;
            end else if (r_state == SHIFT) begin
                r_idx <= r_idx + 1'b1;
            end

            if (r_sr_enb) begin
                r_count <= r_sr_dir ? r_count + 1'b1 : r_count - 1'b1;
            end

            // Popped bits arrive MSB first; the response word doubles as the deserializer.
            if (w_grant || r_rsp_valid) begin
                r_rsp_rdata <= '0;
            end else if (r_sr_enb && (r_sr_dir == OP_POP)) begin
                r_rsp_rdata <= w_rdata_shift;
            end
        end
    end

`ifdef BSR_STACK_CTRL_STATS_EN
    logic [7:0] r_ovf_cnt, r_unf_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_cnt <= '0;
            r_unf_cnt <= '0;
        end else if (w_grant && !w_fit) begin
            if (w_gnt_op == OP_PUSH) begin
                if (r_ovf_cnt != 8'hFF) r_ovf_cnt <= r_ovf_cnt + 1'b1;
            end else begin
                if (r_unf_cnt != 8'hFF) r_unf_cnt <= r_unf_cnt + 1'b1;
            end
        end
    end

    assign ovf_cnt = r_ovf_cnt;
    assign unf_cnt = r_unf_cnt;
`endif

    assign a_gnt     = r_a_gnt;
    assign b_gnt     = r_b_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_err   = r_rsp_err;
    assign rsp_rdata = r_rsp_rdata;
    assign count     = r_count;
    assign full      = int'(r_count) > (DEPTH - WORD_W);
    assign empty     = int'(r_count) < WORD_W;
    assign sr_enb    = r_sr_enb;
    assign sr_dir    = r_sr_dir;
    assign sr_in     = r_sr_in;
    assign sr_rstn   = r_sr_rstn;

endmodule
